// File: rtl/solitaire_pkg.sv
// Shared constants for the solitaire command front end: ASCII codes,
// error encodings and the parser state type.
package solitaire_pkg;

    localparam logic [7:0] CH_BS   = 8'd8;
    localparam logic [7:0] CH_LF   = 8'd10;
    localparam logic [7:0] CH_CR   = 8'd13;
    localparam logic [7:0] CH_ESC  = 8'd27;
    localparam logic [7:0] CH_SP   = 8'd32;
    localparam logic [7:0] CH_ZERO = 8'd48;
    localparam logic [7:0] CH_NINE = 8'd57;
    localparam logic [7:0] CH_DEL  = 8'd127;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_EMPTY   = 3'd1;
    localparam logic [2:0] ERR_RANGE   = 3'd2;
    localparam logic [2:0] ERR_BADCHAR = 3'd3;
    localparam logic [2:0] ERR_ABORT   = 3'd4;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } parser_state_t;

endpackage

// File: rtl/move_cmd_parser_dec_accum.sv
// Decimal field accumulator: builds a number from typed digits, supports
// backspace, and flags digits typed beyond the field's digit limit.
module dec_accum #(
    parameter int DIGITS_MAX = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clear,
    input  logic                               digit_en,
    input  logic [3:0]                         digit_val,
    input  logic                               bs_en,
    output logic [4*DIGITS_MAX-1:0]            acc,
    output logic [$clog2(DIGITS_MAX+1)-1:0]    count,
    output logic                               overflow
);

    localparam int ACC_W = 4 * DIGITS_MAX;
    localparam int CNT_W = $clog2(DIGITS_MAX + 1);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    // ACC_W bits always hold 10**DIGITS_MAX - 1, so acc*10+digit cannot wrap
    always_comb begin
        acc_d      = acc_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clear) begin
            acc_d      = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (digit_en) begin
            if (count_q < CNT_W'(DIGITS_MAX)) begin
                acc_d   = acc_q * ACC_W'(10) + ACC_W'(digit_val);
                count_d = count_q + CNT_W'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end else if (bs_en && (count_q != '0)) begin
            acc_d      = acc_q / ACC_W'(10);
            count_d    = count_q - CNT_W'(1);
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign acc      = acc_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/move_cmd_parser.sv
// Parses an ASCII stream of LF-terminated decimal fields into one move
// command, holding it until the consumer takes it.
module move_cmd_parser
    import solitaire_pkg::*;
#(
    parameter int NUM_FIELDS = 3,
    parameter int FIELD_W    = 4,
    parameter int DIGITS_MAX = 2,
    parameter int MAX_VAL    = 13
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                char_valid,
    input  logic [7:0]                          char_data,
    output logic                                char_ready,
    output logic                                cmd_valid,
    input  logic                                cmd_ready,
    output logic [NUM_FIELDS*FIELD_W-1:0]       cmd_fields,
    output logic [$clog2(NUM_FIELDS+1)-1:0]     field_idx,
    output logic                                err_valid,
    output logic [2:0]                          err_code
);

    localparam int IDX_W = $clog2(NUM_FIELDS + 1);
    localparam int ACC_W = 4 * DIGITS_MAX;
    localparam int CNT_W = $clog2(DIGITS_MAX + 1);

    parser_state_t                 state_q, state_d;
    logic [IDX_W-1:0]              field_idx_q, field_idx_d;
    logic [NUM_FIELDS*FIELD_W-1:0] fields_q, fields_d;
    logic                          err_valid_q, err_valid_d;
    logic [2:0]                    err_code_q, err_code_d;

    logic             digit_en, bs_en, acc_clr, is_digit;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic             overflow;

    dec_accum #(
        .DIGITS_MAX (DIGITS_MAX)
    ) u_dec_accum (
        .clk       (clk),
        .rst       (rst),
        .clear     (acc_clr),
        .digit_en  (digit_en),
        .digit_val (char_data[3:0]),
        .bs_en     (bs_en),
        .acc       (acc),
        .count     (count),
        .overflow  (overflow)
    );

    assign is_digit = (char_data >= CH_ZERO) && (char_data <= CH_NINE);

    always_comb begin
        state_d     = state_q;
        field_idx_d = field_idx_q;
        fields_d    = fields_q;
        err_valid_d = 1'b0;
        err_code_d  = ERR_NONE;
        digit_en    = 1'b0;
        bs_en       = 1'b0;
        acc_clr     = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                if (char_valid) begin
                    if (is_digit) begin
                        digit_en = 1'b1;
                    end else if ((char_data == CH_BS) || (char_data == CH_DEL)) begin
                        bs_en = 1'b1;
                    end else if ((char_data == CH_SP) || (char_data == CH_CR)) begin
                        acc_clr = 1'b0;
                    end else if (char_data == CH_LF) begin
                        acc_clr = 1'b1;
                        if (count == '0) begin
                            err_valid_d = 1'b1;
                            err_code_d  = ERR_EMPTY;
                        end else if (overflow || (acc > ACC_W'(MAX_VAL))) begin
                            err_valid_d = 1'b1;
                            err_code_d  = ERR_RANGE;
                        end else begin
                            for (int k = 0; k < NUM_FIELDS; k++) begin
                                if (field_idx_q == IDX_W'(k)) begin
                                    fields_d[k*FIELD_W +: FIELD_W] = FIELD_W'(acc);
                                end
                            end
                            field_idx_d = field_idx_q + IDX_W'(1);
                            // Storing the final field completes the command
                            if (field_idx_q == IDX_W'(NUM_FIELDS - 1)) begin
                                state_d = ST_HOLD;
                            end
                        end
                    end else if (char_data == CH_ESC) begin
                        acc_clr     = 1'b1;
                        fields_d    = '0;
                        field_idx_d = '0;
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_ABORT;
                    end else begin
                        acc_clr     = 1'b1;
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_BADCHAR;
                    end
                end
            end
            ST_HOLD: begin
                if (cmd_ready) begin
                    state_d     = ST_COLLECT;
                    field_idx_d = '0;
                    acc_clr     = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_COLLECT;
            field_idx_q <= '0;
            fields_q    <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            field_idx_q <= field_idx_d;
            fields_q    <= fields_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    assign char_ready = (state_q == ST_COLLECT);
    assign cmd_valid  = (state_q == ST_HOLD);
    assign cmd_fields = fields_q;
    assign field_idx  = field_idx_q;
    assign err_valid  = err_valid_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_move_cmd_parser.sv
// Self-checking bench for move_cmd_parser: directed scenarios plus a random
// character stream compared against a digit-list reference model.
module tb_move_cmd_parser;

    localparam int NF = 3;
    localparam int FW = 4;
    localparam int DM = 2;
    localparam int MV = 13;

    logic          clk = 1'b0;
    logic          rst;
    logic          char_valid;
    logic [7:0]    char_data;
    logic          char_ready;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [NF*FW-1:0] cmd_fields;
    logic [1:0]    field_idx;
    logic          err_valid;
    logic [2:0]    err_code;

    int checks = 0;
    int errors = 0;

    // Reference model: the field being typed is kept as a list of digits
    int  m_digits[$];
    bit  m_ovf;
    int  m_fields[NF];
    int  m_idx;
    bit  m_hold;
    bit  m_err_v;
    int  m_err_c;

    move_cmd_parser #(
        .NUM_FIELDS (NF),
        .FIELD_W    (FW),
        .DIGITS_MAX (DM),
        .MAX_VAL    (MV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_fields (cmd_fields),
        .field_idx  (field_idx),
        .err_valid  (err_valid),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    function automatic logic [NF*FW-1:0] exp_fields();
        logic [NF*FW-1:0] f = '0;
        for (int k = 0; k < NF; k++) f[k*FW +: FW] = FW'(m_fields[k]);
        return f;
    endfunction

    task automatic model_reset();
        m_digits.delete();
        m_ovf   = 0;
        m_idx   = 0;
        m_hold  = 0;
        m_err_v = 0;
        m_err_c = 0;
        for (int k = 0; k < NF; k++) m_fields[k] = 0;
    endtask

    task automatic model_edge(input bit v, input logic [7:0] d, input bit r);
        int val;
        m_err_v = 0;
        m_err_c = 0;
        if (m_hold) begin
            if (r) begin
                m_hold = 0;
                m_idx  = 0;
            end
        end else if (v) begin
            if (d >= 8'h30 && d <= 8'h39) begin
                if (m_digits.size() < DM) m_digits.push_back(int'(d) - 48);
                else m_ovf = 1;
            end else if (d == 8'd8 || d == 8'd127) begin
                if (m_digits.size() > 0) begin
                    m_digits.delete(m_digits.size() - 1);
                    m_ovf = 0;
                end
            end else if (d == 8'd32 || d == 8'd13) begin
                m_err_v = 0;
            end else if (d == 8'd10) begin
                val = 0;
                foreach (m_digits[i]) val = val * 10 + m_digits[i];
                if (m_digits.size() == 0) begin
                    m_err_v = 1; m_err_c = 1;
                end else if (m_ovf || val > MV) begin
                    m_err_v = 1; m_err_c = 2;
                end else begin
                    m_fields[m_idx] = val;
                    m_idx++;
                    if (m_idx == NF) m_hold = 1;
                end
                m_digits.delete();
                m_ovf = 0;
            end else if (d == 8'd27) begin
                m_digits.delete();
                m_ovf = 0;
                for (int k = 0; k < NF; k++) m_fields[k] = 0;
                m_idx = 0;
                m_err_v = 1; m_err_c = 4;
            end else begin
                m_digits.delete();
                m_ovf = 0;
                m_err_v = 1; m_err_c = 3;
            end
        end
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit r);
        @(negedge clk);
        char_valid = v;
        char_data  = d;
        cmd_ready  = r;
        @(posedge clk);
        model_edge(v, d, r);
        #1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) step(1'b1, s[i], 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        char_valid = 1'b0;
        char_data  = 8'd0;
        cmd_ready  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst        = 1'b1;
        char_valid = 1'b0;
        char_data  = 8'd0;
        cmd_ready  = 1'b0;
        model_reset();
        #1;
        checks++; if (char_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_char_ready: got %b want 1", char_ready); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_cmd_valid: got %b want 0", cmd_valid); end
        checks++; if (cmd_fields !== 12'h000) begin errors++; $display("[TB] FAIL rst_fields: got %h want 000", cmd_fields); end
        checks++; if (field_idx !== 2'd0) begin errors++; $display("[TB] FAIL rst_idx: got %0d want 0", field_idx); end
        checks++; if (err_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_err_valid: got %b want 0", err_valid); end
        checks++; if (err_code !== 3'd0) begin errors++; $display("[TB] FAIL rst_err_code: got %0d want 0", err_code); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_command();
        do_reset();
        send_str("3\n2\n");
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL cmd_early: got %b want 0", cmd_valid); end
        send_str("7\n");
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("[TB] FAIL cmd_rise: got %b want 1", cmd_valid); end
        checks++; if (cmd_fields !== 12'h723) begin errors++; $display("[TB] FAIL cmd_fields: got %h want 723", cmd_fields); end
        checks++; if (char_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_ready: got %b want 0", char_ready); end
        for (int i = 0; i < 2; i++) begin
            step(1'b1, "5", 1'b0);
            checks++; if (char_ready !== 1'b0 || cmd_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_stall: got ready %b valid %b want 0 1", char_ready, cmd_valid); end
            checks++; if (cmd_fields !== 12'h723) begin errors++; $display("[TB] FAIL hold_stable: got %h want 723", cmd_fields); end
        end
        step(1'b0, 8'd0, 1'b1);
        checks++; if (cmd_valid !== 1'b0 || char_ready !== 1'b1) begin errors++; $display("[TB] FAIL release: got valid %b ready %b want 0 1", cmd_valid, char_ready); end
        checks++; if (field_idx !== 2'd0) begin errors++; $display("[TB] FAIL release_idx: got %0d want 0", field_idx); end
        send_str("\n");
        checks++; if (err_valid !== 1'b1 || err_code !== 3'd1) begin errors++; $display("[TB] FAIL hold_drop: got v %b code %0d want 1 1", err_valid, err_code); end
    endtask

    task automatic test_range();
        send_str("14\n");
        checks++; if (err_valid !== 1'b1 || err_code !== 3'd2) begin errors++; $display("[TB] FAIL range14: got v %b code %0d want 1 2", err_valid, err_code); end
        checks++; if (field_idx !== 2'd0) begin errors++; $display("[TB] FAIL range_idx: got %0d want 0", field_idx); end
        step(1'b0, 8'd0, 1'b0);
        checks++; if (err_valid !== 1'b0) begin errors++; $display("[TB] FAIL err_pulse_len: got %b want 0", err_valid); end
        send_str("12\n");
        checks++; if (field_idx !== 2'd1 || cmd_fields[3:0] !== 4'd12) begin errors++; $display("[TB] FAIL store12: got idx %0d f0 %0d want 1 12", field_idx, cmd_fields[3:0]); end
    endtask

    task automatic test_backspace();
        do_reset();
        send_str("5");
        step(1'b1, 8'd8, 1'b0);
        send_str("6\n");
        checks++; if (field_idx !== 2'd1 || cmd_fields[3:0] !== 4'd6) begin errors++; $display("[TB] FAIL bs_edit: got idx %0d f0 %0d want 1 6", field_idx, cmd_fields[3:0]); end
        step(1'b1, 8'd8, 1'b0);
        checks++; if (err_valid !== 1'b0 || field_idx !== 2'd1) begin errors++; $display("[TB] FAIL bs_empty: got v %b idx %0d want 0 1", err_valid, field_idx); end
        send_str("9");
        step(1'b1, 8'd127, 1'b0);
        send_str("\n");
        checks++; if (err_valid !== 1'b1 || err_code !== 3'd1) begin errors++; $display("[TB] FAIL del_empty: got v %b code %0d want 1 1", err_valid, err_code); end
    endtask

    task automatic test_badchar_abort();
        do_reset();
        send_str("2\nx");
        checks++; if (err_valid !== 1'b1 || err_code !== 3'd3 || field_idx !== 2'd1) begin errors++; $display("[TB] FAIL badchar: got v %b code %0d idx %0d want 1 3 1", err_valid, err_code, field_idx); end
        step(1'b1, 8'd27, 1'b0);
        checks++; if (err_valid !== 1'b1 || err_code !== 3'd4 || field_idx !== 2'd0) begin errors++; $display("[TB] FAIL abort: got v %b code %0d idx %0d want 1 4 0", err_valid, err_code, field_idx); end
        checks++; if (cmd_fields !== 12'h000) begin errors++; $display("[TB] FAIL abort_fields: got %h want 000", cmd_fields); end
    endtask

    task automatic test_overflow_empty();
        do_reset();
        send_str("123\n");
        checks++; if (err_valid !== 1'b1 || err_code !== 3'd2) begin errors++; $display("[TB] FAIL digit_ovf: got v %b code %0d want 1 2", err_valid, err_code); end
        send_str("\n");
        checks++; if (err_valid !== 1'b1 || err_code !== 3'd1) begin errors++; $display("[TB] FAIL empty: got v %b code %0d want 1 1", err_valid, err_code); end
        send_str("13\n");
        checks++; if (field_idx !== 2'd1 || cmd_fields[3:0] !== 4'd13) begin errors++; $display("[TB] FAIL max_val: got idx %0d f0 %0d want 1 13", field_idx, cmd_fields[3:0]); end
        send_str(" 9\r\n");
        checks++; if (field_idx !== 2'd2 || cmd_fields[7:4] !== 4'd9) begin errors++; $display("[TB] FAIL ignore_ws: got idx %0d f1 %0d want 2 9", field_idx, cmd_fields[7:4]); end
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        send_str("1\n2\n3\n");
        checks++; if (cmd_valid !== 1'b1 || cmd_fields !== 12'h321) begin errors++; $display("[TB] FAIL pre_rst_hold: got v %b f %h want 1 321", cmd_valid, cmd_fields); end
        #2;
        rst = 1'b1;
        char_valid = 1'b0;
        model_reset();
        #1;
        checks++; if (cmd_valid !== 1'b0 || char_ready !== 1'b1) begin errors++; $display("[TB] FAIL async_rst: got v %b ready %b want 0 1", cmd_valid, char_ready); end
        checks++; if (cmd_fields !== 12'h000 || field_idx !== 2'd0 || err_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_clear: got f %h idx %0d ev %b want 000 0 0", cmd_fields, field_idx, err_valid); end
        @(negedge clk);
        rst = 1'b0;
        send_str("5");
        #2;
        rst = 1'b1;
        char_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 8'd0, 1'b0);
        checks++; if (err_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_no_err: got %b want 0", err_valid); end
        send_str("\n");
        checks++; if (err_valid !== 1'b1 || err_code !== 3'd1) begin errors++; $display("[TB] FAIL rst_partial: got v %b code %0d want 1 1", err_valid, err_code); end
    endtask

    function automatic logic [7:0] rand_char();
        int p = $urandom_range(0, 99);
        if (p < 55) return 8'h30 + 8'($urandom_range(0, 9));
        if (p < 75) return 8'd10;
        if (p < 80) return 8'd8;
        if (p < 83) return 8'd127;
        if (p < 87) return 8'd32;
        if (p < 90) return 8'd13;
        if (p < 92) return 8'd27;
        if (p < 96) return "x";
        return "?";
    endfunction

    task automatic test_random();
        bit v, r;
        logic [7:0] c;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            v = ($urandom_range(0, 9) < 8);
            r = ($urandom_range(0, 9) < 3);
            c = rand_char();
            step(v, c, r);
            checks++; if (char_ready !== !m_hold || cmd_valid !== m_hold) begin errors++; $display("[TB] FAIL rnd_state n=%0d: got ready %b valid %b want hold %b", n, char_ready, cmd_valid, m_hold); end
            checks++; if (field_idx !== 2'(m_idx)) begin errors++; $display("[TB] FAIL rnd_idx n=%0d: got %0d want %0d", n, field_idx, m_idx); end
            checks++; if (cmd_fields !== exp_fields()) begin errors++; $display("[TB] FAIL rnd_fields n=%0d: got %h want %h", n, cmd_fields, exp_fields()); end
            checks++; if (err_valid !== m_err_v) begin errors++; $display("[TB] FAIL rnd_err_valid n=%0d: got %b want %b", n, err_valid, m_err_v); end
            if (m_err_v) begin
                checks++; if (err_code !== 3'(m_err_c)) begin errors++; $display("[TB] FAIL rnd_err_code n=%0d: got %0d want %0d", n, err_code, m_err_c); end
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        char_valid = 1'b0;
        char_data  = 8'd0;
        cmd_ready  = 1'b0;
        model_reset();
        test_reset();
        test_command();
        test_range();
        test_backspace();
        test_badchar_abort();
        test_overflow_empty();
        test_reset_in_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/move_cmd_parser.md
MOVE_CMD_PARSER -- requirements
Module: move_cmd_parser

Interface
REQ-001 SHALL have parameter NUM_FIELDS, default 3, number of numeric fields per command (source, offset, destination).
REQ-002 SHALL have parameter FIELD_W, default 4, bit width of each output field.
REQ-003 SHALL have parameter DIGITS_MAX, default 2, maximum decimal digits accepted per field.
REQ-004 SHALL have parameter MAX_VAL, default 13, largest legal field value; MAX_VAL < 2**FIELD_W.
REQ-005 SHALL have port clk  in  1  single clock, rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port char_valid  in  1  an input character is offered.
REQ-008 SHALL have port char_data  in  8  ASCII character.
REQ-009 SHALL have port char_ready  out  1  parser accepts a character this cycle.
REQ-010 SHALL have port cmd_valid  out  1  completed command is held.
REQ-011 SHALL have port cmd_ready  in  1  consumer takes the command.
REQ-012 SHALL have port cmd_fields  out  NUM_FIELDS*FIELD_W  field k at bits [k*FIELD_W +: FIELD_W]; field 0 is entered first.
REQ-013 SHALL have port field_idx  out  $clog2(NUM_FIELDS+1)  index of the field being entered; drives the prompt.
REQ-014 SHALL have port err_valid  out  1  one-cycle error pulse.
REQ-015 SHALL have port err_code  out  3  error cause; valid while err_valid is high.

Function
REQ-016 SHALL accept a character when char_valid && char_ready at a clock edge.
REQ-017 SHALL have two states: COLLECT (char_ready=1, cmd_valid=0) and HOLD (char_ready=0, cmd_valid=1).
REQ-018 SHALL, in COLLECT, on digit '0'-'9' with digit count < DIGITS_MAX, set acc = acc*10 + digit and increment the count; acc width SHALL be 4*DIGITS_MAX.
REQ-019 SHALL, on a digit with count == DIGITS_MAX, leave acc unchanged and set the field's overflow flag.
REQ-020 SHALL, on backspace (8) or DEL (127) with count > 0, set acc = acc/10, decrement the count and clear the overflow flag; with count == 0 it SHALL take no action.
REQ-021 SHALL ignore space (32) and CR (13).
REQ-022 SHALL, on LF (10), complete the field:
- count==0: ERR_EMPTY
- overflow or acc > MAX_VAL: ERR_RANGE
- otherwise: store acc to field field_idx, increment field_idx
REQ-023 SHALL, on any error, clear acc, count and overflow and keep field_idx and the fields already stored.
REQ-024 SHALL, on ESC (27), clear acc, count and all stored fields, set field_idx=0 and raise ERR_ABORT.
REQ-025 SHALL, on any other character, raise ERR_BADCHAR and clear only the current field.
REQ-026 SHALL enter HOLD on the clock edge that stores the last field; cmd_valid SHALL rise on that edge, so latency from LF acceptance is 1 cycle.
REQ-027 SHALL hold cmd_fields stable in HOLD until cmd_valid && cmd_ready; on that edge it SHALL return to COLLECT with field_idx=0 and acc cleared.
REQ-028 SHALL keep cmd_fields at their last value in COLLECT; fields not yet rewritten SHALL hold stale data, and consumers SHALL sample only on cmd_valid.
REQ-029 SHALL encode err_code as: 0 none, 1 EMPTY, 2 RANGE, 3 BADCHAR, 4 ABORT; err_valid SHALL be high for exactly the cycle after the offending character is accepted.
REQ-030 SHALL drop characters offered during HOLD; char_ready=0 applies backpressure.

Reset
REQ-031 SHALL, while rst is high, hold state=COLLECT, char_ready=1, cmd_valid=0, cmd_fields=0, field_idx=0, acc=0, count=0, overflow=0, err_valid=0, err_code=0.
REQ-032 SHALL, when rst is asserted mid-command or in HOLD, discard all partial and held data with no err pulse.

Structure
REQ-033 SHALL place the ASCII constants (LF, CR, SP, BS, DEL, ESC, '0') and the err_code encodings in shared package solitaire_pkg.
REQ-034 SHALL contain one sub-module, dec_accum, holding acc, count and overflow and performing the digit and backspace updates.

Verification
REQ-035 SHALL verify with defaults: "3\n", "2\n", "7\n" -> cmd_valid rises 1 cycle after the 3rd LF; cmd_fields = {7,2,3}; char_ready=0 until cmd_ready.
REQ-036 SHALL verify: "1","4","\n" -> err_valid with code 2 (RANGE), field_idx stays 0; then "12\n" -> field 0 = 12.
REQ-037 SHALL verify: "5", BS, "6\n" -> field 0 = 6; BS with count 0 -> no error and no change.
REQ-038 SHALL verify: "2\n", "x" -> err_code 3 with field_idx 1; ESC -> err_code 4 with field_idx 0.
REQ-039 SHALL verify: "1","2","3","\n" with DIGITS_MAX=2 -> ERR_RANGE; "\n" alone -> ERR_EMPTY.
REQ-040 SHALL verify: rst asserted in HOLD -> cmd_valid=0 immediately (asynchronous), cmd_fields=0, field_idx=0, no err pulse.
